// File: rtl/mpt_pkg.sv
// Shared MPT walker / PLB types: access kinds, permission encodings,
// flush control/status, PLB entry, lookup request and response formats.
package mpt_pkg;

   localparam int XLEN            = 64;
   localparam int MPT_SDID_WIDTH  = 6;
   localparam int ROB_ID_WIDTH    = 4;
   localparam int PLB_PAGE_OFFSET = 12;

   // PLB tag is the SDID concatenated with the SPA page number.
   localparam int PLB_TAG_WIDTH = MPT_SDID_WIDTH + XLEN - PLB_PAGE_OFFSET;

   typedef logic [ROB_ID_WIDTH-1:0]   rob_id_size_t;
   typedef logic [MPT_SDID_WIDTH-1:0] mpt_sdid_t;
   typedef logic [PLB_TAG_WIDTH-1:0]  plb_tag_t;

   typedef enum logic [1:0] {
      ACCESS_NONE  = 2'd0,
      ACCESS_READ  = 2'd1,
      ACCESS_WRITE = 2'd2,
      ACCESS_EXEC  = 2'd3
   } mpt_access_e;

   // Bit 0 = read, bit 1 = write, bit 2 = execute.
   typedef enum logic [2:0] {
      ALLOW_NONE = 3'd0,
      ALLOW_R    = 3'd1,
      ALLOW_W    = 3'd2,
      ALLOW_RW   = 3'd3,
      ALLOW_X    = 3'd4,
      ALLOW_RX   = 3'd5,
      ALLOW_WX   = 3'd6,
      ALLOW_RWX  = 3'd7
   } mpt_permissions_e;

   typedef enum logic [1:0] {
      MPT_FLUSH_NONE   = 2'd0,
      MPT_FLUSH_ALL    = 2'd1,
      MPT_FLUSH_SPEC   = 2'd2,
      MPT_FLUSH_UNUSED = 2'd3
   } mptw_flush_ctrl_e;

   typedef enum logic [1:0] {
      MPT_FLUSHED_NONE      = 2'd0,
      MPT_FLUSHED_ONGOING   = 2'd1,
      MPT_FLUSHED_COMPLETED = 2'd2
   } mptw_flush_status_e;

   // Flush sequencer states inside the PLB.
   typedef enum logic [1:0] {
      PLB_FL_IDLE  = 2'd0,
      PLB_FL_DRAIN = 2'd1,
      PLB_FL_DONE  = 2'd2
   } plb_flush_state_e;

   typedef struct packed {
      mpt_sdid_t        sdid;
      logic [XLEN-1:0]  spa;
      mpt_permissions_e perms;
   } plb_entry_t;

   typedef struct packed {
      mpt_sdid_t       sdid;
      logic [XLEN-1:0] spa;
      mpt_access_e     access_type;
   } plb_lookup_req_t;

   typedef struct packed {
      rob_id_size_t     id;
      logic             hit;
      logic             allow;
      mpt_permissions_e perms;
   } plb_resp_t;

   // Build the page-granular tag used by both lookups and fills.
   function automatic plb_tag_t plb_tag(input mpt_sdid_t sdid, input logic [XLEN-1:0] spa);
      return {sdid, spa[XLEN-1:PLB_PAGE_OFFSET]};
   endfunction

   // Permission check for one access kind; ACCESS_NONE never passes.
   function automatic logic plb_allow(input mpt_access_e acc, input mpt_permissions_e perms);
      logic [2:0] p;
      logic       ok;
      p = perms;
      case (acc)
         ACCESS_READ:  ok = p[0];
         ACCESS_WRITE: ok = p[1];
         ACCESS_EXEC:  ok = p[2];
         default:      ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mpt_plb_victim_sel.sv
// Fill slot selection for the PLB: the lowest-index invalid entry wins;
// when every entry is valid the round-robin pointer names the victim and
// replace_o tells the caller to advance that pointer.
module mpt_plb_victim_sel
   import mpt_pkg::*;
#(
   parameter int NUM_ENTRIES = 8,
   localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
   input  logic [NUM_ENTRIES-1:0] valid_i,
   input  logic [IDX_W-1:0]       ptr_i,
   output logic [IDX_W-1:0]       victim_idx_o,
   output logic                   replace_o
);

   // Priority-encode the first free slot, scanning from the top so the
   // lowest index is the last (winning) assignment.
   always_comb begin
      victim_idx_o = ptr_i;
      replace_o    = 1'b1;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!valid_i[i]) begin
            victim_idx_o = IDX_W'(i);
            replace_o    = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mpt_plb.sv
// Protection Lookaside Buffer. Fully-associative cache of page-granular
// {SDID, SPA page, permissions} translations installed by the walker's
// retire stage, answering lookups from its issue stage with a one-cycle
// registered hit/permission response. A small flush sequencer drains the
// response register before optionally invalidating every entry.
//
// Handshakes: a lookup transfers on a rising edge where lookup_valid_i and
// lookup_ready_o are both high; a response transfers on a rising edge where
// resp_valid_o and resp_ready_i are both high, and resp_o is held stable
// while resp_valid_o is high and resp_ready_i is low. Fills are one-cycle
// pulses with no backpressure and are dropped while a flush is in progress.
module mpt_plb
   import mpt_pkg::*;
#(
   parameter int NUM_ENTRIES = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               lookup_valid_i,
   output logic               lookup_ready_o,
   input  plb_lookup_req_t    lookup_req_i,
   input  rob_id_size_t       lookup_id_i,
   output logic               resp_valid_o,
   input  logic               resp_ready_i,
   output plb_resp_t          resp_o,
   input  logic               fill_valid_i,
   input  plb_entry_t         fill_entry_i,
   input  mptw_flush_ctrl_e   flush_ctrl_i,
   output mptw_flush_status_e flush_status_o
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);

   // Entry storage: valid bits live apart from the tag/permission arrays.
   logic [NUM_ENTRIES-1:0] valid_q;
   plb_tag_t               tag_q   [NUM_ENTRIES];
   mpt_permissions_e       perms_q [NUM_ENTRIES];
   logic [IDX_W-1:0]       rr_ptr_q;

   // Response register.
   logic                   resp_valid_q;
   plb_resp_t              resp_q;

   // Flush sequencer.
   plb_flush_state_e       state_q;
   logic                   flush_all_q;
   mptw_flush_status_e     flush_status_q;

   // Combinational lookup / fill search results.
   plb_tag_t               lk_tag;
   logic                   lk_hit;
   mpt_permissions_e       lk_perms;
   plb_tag_t               fl_tag;
   logic                   fl_match;
   logic [IDX_W-1:0]       fl_match_idx;
   logic [IDX_W-1:0]       victim_idx;
   logic                   victim_replace;
   logic [IDX_W-1:0]       fill_idx;
   logic                   fill_write;
   logic                   lookup_accept;
   logic                   drain_done;
   logic                   flush_clear;

   // Page-offset bits of both addresses are intentionally ignored.
   logic                   unused_offset_bits;
   assign unused_offset_bits = ^{lookup_req_i.spa[PLB_PAGE_OFFSET-1:0],
                                 fill_entry_i.spa[PLB_PAGE_OFFSET-1:0]};

   // Lookup CAM: compares against current contents, so a fill on the same
   // edge is not yet visible. At most one entry can match.
   always_comb begin
      lk_tag   = plb_tag(lookup_req_i.sdid, lookup_req_i.spa);
      lk_hit   = 1'b0;
      lk_perms = ALLOW_NONE;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (valid_q[i] && (tag_q[i] == lk_tag)) begin
            lk_hit   = 1'b1;
            lk_perms = perms_q[i];
         end
      end
   end

   // Fill CAM: an existing tag is rewritten in place, which keeps tags unique.
   always_comb begin
      fl_tag       = plb_tag(fill_entry_i.sdid, fill_entry_i.spa);
      fl_match     = 1'b0;
      fl_match_idx = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (valid_q[i] && (tag_q[i] == fl_tag)) begin
            fl_match     = 1'b1;
            fl_match_idx = IDX_W'(i);
         end
      end
   end

   mpt_plb_victim_sel #(
      .NUM_ENTRIES (NUM_ENTRIES)
   ) u_victim_sel (
      .valid_i      (valid_q),
      .ptr_i        (rr_ptr_q),
      .victim_idx_o (victim_idx),
      .replace_o    (victim_replace)
   );

   assign fill_write    = fill_valid_i && (state_q == PLB_FL_IDLE);
   assign fill_idx      = fl_match ? fl_match_idx : victim_idx;
   assign drain_done    = !resp_valid_q || resp_ready_i;
   assign flush_clear   = (state_q == PLB_FL_DRAIN) && drain_done && flush_all_q;
   assign lookup_ready_o = (!resp_valid_q || resp_ready_i) && (state_q == PLB_FL_IDLE);
   assign lookup_accept = lookup_valid_i && lookup_ready_o;

   // Valid bits and round-robin pointer; the pointer only moves when a
   // valid entry is evicted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q  <= '0;
         rr_ptr_q <= '0;
      end else if (flush_clear) begin
         valid_q  <= '0;
      end else if (fill_write) begin
         valid_q[fill_idx] <= 1'b1;
         if (!fl_match && victim_replace) begin
            rr_ptr_q <= rr_ptr_q + 1'b1;
         end
      end
   end

   // Tag and permission payload; only meaningful where the valid bit is set.
   always_ff @(posedge clk_i) begin
      if (fill_write) begin
         tag_q[fill_idx]   <= fl_tag;
         perms_q[fill_idx] <= fill_entry_i.perms;
      end
   end

   // Response register: load on an accepted lookup, clear valid on handshake.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         resp_valid_q <= 1'b0;
         resp_q       <= '0;
      end else if (lookup_accept) begin
         resp_valid_q <= 1'b1;
         resp_q.id    <= lookup_id_i;
         resp_q.hit   <= lk_hit;
         resp_q.allow <= lk_hit && plb_allow(lookup_req_i.access_type, lk_perms);
         resp_q.perms <= lk_hit ? lk_perms : ALLOW_NONE;
      end else if (resp_ready_i) begin
         resp_valid_q <= 1'b0;
      end
   end

   // Flush sequencer with registered status: IDLE -> DRAIN until the response
   // register is empty or emptying, then DONE for exactly one cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= PLB_FL_IDLE;
         flush_all_q    <= 1'b0;
         flush_status_q <= MPT_FLUSHED_NONE;
      end else begin
         case (state_q)
            PLB_FL_IDLE: begin
               if ((flush_ctrl_i == MPT_FLUSH_ALL) || (flush_ctrl_i == MPT_FLUSH_SPEC)) begin
                  state_q        <= PLB_FL_DRAIN;
                  flush_all_q    <= (flush_ctrl_i == MPT_FLUSH_ALL);
                  flush_status_q <= MPT_FLUSHED_ONGOING;
               end
            end
            PLB_FL_DRAIN: begin
               if (drain_done) begin
                  state_q        <= PLB_FL_DONE;
                  flush_status_q <= MPT_FLUSHED_COMPLETED;
               end
            end
            PLB_FL_DONE: begin
               state_q        <= PLB_FL_IDLE;
               flush_status_q <= MPT_FLUSHED_NONE;
            end
            default: begin
               state_q        <= PLB_FL_IDLE;
               flush_status_q <= MPT_FLUSHED_NONE;
            end
         endcase
      end
   end

   assign resp_valid_o   = resp_valid_q;
   assign resp_o         = resp_q;
   assign flush_status_o = flush_status_q;

endmodule
